// File: rtl/wb_pkg.sv
// Shared Wishbone arbiter definitions: bus widths, FSM state encoding and a
// one-hot to index helper.
package wb_pkg;

  localparam int unsigned WB_AW  = 32;
  localparam int unsigned WB_DW  = 128;
  localparam int unsigned WB_SW  = WB_DW / 8;
  localparam int unsigned WB_WDW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } wb_arb_state_e;

  // Index of the set bit in a one-hot vector of up to 8 requesters.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping) receives the one-hot grant.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [N-1:0] rot;
  logic [N-1:0] pri;

  // Rotate so ptr sits at bit 0, keep the lowest set bit, rotate back.
  always_comb begin
    rot = (req >> ptr) | (req << (N - 32'(ptr)));
    pri = rot & (~rot + N'(1));
    gnt = (pri << ptr) | (pri >> (N - 32'(ptr)));
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin Wishbone arbiter: shares one bus among NM masters, holds the
// grant for a whole cyc burst and aborts hung transfers with a watchdog.
module wb_master_arbiter
  import wb_pkg::*;
#(
  parameter  int unsigned NM      = 2,
  parameter  int unsigned AW      = WB_AW,
  parameter  int unsigned DW      = WB_DW,
  parameter  int unsigned TIMEOUT = 255,
  localparam int unsigned SW      = DW / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NM*AW-1:0] i_rq_wb_adr,
  input  logic [NM*SW-1:0] i_rq_wb_sel,
  input  logic [NM-1:0]    i_rq_wb_we,
  input  logic [NM*DW-1:0] i_rq_wb_dat,
  input  logic [NM-1:0]    i_rq_wb_cyc,
  input  logic [NM-1:0]    i_rq_wb_stb,
  output logic [DW-1:0]    o_rq_wb_dat,
  output logic [NM-1:0]    o_rq_wb_ack,
  output logic [NM-1:0]    o_rq_wb_err,
  output logic [AW-1:0]    o_wb_adr,
  output logic [SW-1:0]    o_wb_sel,
  output logic             o_wb_we,
  output logic [DW-1:0]    o_wb_dat,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  input  logic [DW-1:0]    i_wb_dat,
  input  logic             i_wb_ack,
  input  logic             i_wb_err,
  output logic [NM-1:0]    o_grant
);

  localparam int unsigned PW = (NM > 1) ? $clog2(NM) : 1;

  wb_arb_state_e       state_q, state_d;
  logic [NM-1:0]       grant_q, grant_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [WB_WDW-1:0]   wd_q, wd_d;

  logic [NM-1:0]       arb_gnt;
  logic [2:0]          owner_idx;
  logic [PW-1:0]       next_ptr;
  logic [WB_WDW-1:0]   wd_inc;
  logic                busy;
  logic                owner_cyc;
  logic                owner_stb;
  logic                bus_stb_c;
  logic [AW-1:0]       mux_adr;
  logic [SW-1:0]       mux_sel;
  logic                mux_we;
  logic [DW-1:0]       mux_dat;

  rr_arbiter #(.N(NM)) u_rr (
    .req (i_rq_wb_cyc),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  assign busy      = (state_q == ST_BUSY);
  assign owner_idx = onehot_to_idx(8'(grant_q));
  assign next_ptr  = (owner_idx == 3'(NM - 1)) ? '0 : PW'(owner_idx + 3'd1);
  assign wd_inc    = wd_q + WB_WDW'(1);

  // AND-OR mux of the owner's request onto the shared bus.
  always_comb begin
    mux_adr   = '0;
    mux_sel   = '0;
    mux_we    = 1'b0;
    mux_dat   = '0;
    owner_cyc = 1'b0;
    owner_stb = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (grant_q[k]) begin
        mux_adr   = mux_adr | i_rq_wb_adr[k*AW +: AW];
        mux_sel   = mux_sel | i_rq_wb_sel[k*SW +: SW];
        mux_we    = mux_we | i_rq_wb_we[k];
        mux_dat   = mux_dat | i_rq_wb_dat[k*DW +: DW];
        owner_cyc = owner_cyc | i_rq_wb_cyc[k];
        owner_stb = owner_stb | i_rq_wb_stb[k];
      end
    end
  end

  assign bus_stb_c   = busy & owner_cyc & owner_stb;
  assign o_wb_cyc    = busy & owner_cyc;
  assign o_wb_stb    = bus_stb_c;
  assign o_wb_adr    = busy ? mux_adr : '0;
  assign o_wb_sel    = busy ? mux_sel : '0;
  assign o_wb_we     = busy & mux_we;
  assign o_wb_dat    = busy ? mux_dat : '0;
  assign o_rq_wb_dat = busy ? i_wb_dat : '0;
  assign o_rq_wb_ack = grant_q & {NM{busy & i_wb_ack}};
  assign o_rq_wb_err = grant_q & {NM{(busy & i_wb_err) | (state_q == ST_ABORT)}};
  assign o_grant     = grant_q;

  // Next-state: arbitration, release, and watchdog expiry.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    unique case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (|i_rq_wb_cyc) begin
          grant_d = arb_gnt;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!owner_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = next_ptr;
          wd_d    = '0;
        end else if (i_wb_ack || i_wb_err || !bus_stb_c) begin
          wd_d = '0;
        end else begin
          wd_d = wd_inc;
          if ((TIMEOUT != 0) && (wd_inc == WB_WDW'(TIMEOUT))) begin
            state_d = ST_ABORT;
            wd_d    = '0;
          end
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
        grant_d = '0;
        ptr_d   = next_ptr;
        wd_d    = '0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter: directed vector table, corner
// sequences, and randomized traffic against a transaction-level model.
module tb_wb_master_arbiter;

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NM*AW-1:0] rq_adr;
  logic [NM*SW-1:0] rq_sel;
  logic [NM-1:0]    rq_we;
  logic [NM*DW-1:0] rq_dat;
  logic [NM-1:0]    rq_cyc;
  logic [NM-1:0]    rq_stb;
  logic [DW-1:0]    rq_rdat;
  logic [NM-1:0]    rq_ack;
  logic [NM-1:0]    rq_err;
  logic [AW-1:0]    wb_adr;
  logic [SW-1:0]    wb_sel;
  logic             wb_we;
  logic [DW-1:0]    wb_dat;
  logic             wb_cyc;
  logic             wb_stb;
  logic [DW-1:0]    s_dat;
  logic             s_ack;
  logic             s_err;
  logic [NM-1:0]    grant;

  int n_checks = 0;
  int n_errors = 0;

  wb_master_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rq_wb_adr (rq_adr),
    .i_rq_wb_sel (rq_sel),
    .i_rq_wb_we  (rq_we),
    .i_rq_wb_dat (rq_dat),
    .i_rq_wb_cyc (rq_cyc),
    .i_rq_wb_stb (rq_stb),
    .o_rq_wb_dat (rq_rdat),
    .o_rq_wb_ack (rq_ack),
    .o_rq_wb_err (rq_err),
    .o_wb_adr    (wb_adr),
    .o_wb_sel    (wb_sel),
    .o_wb_we     (wb_we),
    .o_wb_dat    (wb_dat),
    .o_wb_cyc    (wb_cyc),
    .o_wb_stb    (wb_stb),
    .i_wb_dat    (s_dat),
    .i_wb_ack    (s_ack),
    .i_wb_err    (s_err),
    .o_grant     (grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rq_adr = '0; rq_sel = '0; rq_we = '0; rq_dat = '0;
    rq_cyc = '0; rq_stb = '0;
    s_ack = 1'b0; s_err = 1'b0; s_dat = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference model: who owns the bus, whether it is being aborted, whose
  // turn is next, and how long the current strobe has waited.
  int m_owner;
  int m_ptr;
  int m_age;
  bit m_abort;

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_age = 0; m_abort = 1'b0;
  endtask

  task automatic model_check();
    bit busy;
    logic [NM-1:0] eg;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_wdat, e_rdat;
    busy = (m_owner >= 0) && !m_abort;
    eg = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    e_adr = '0; e_wdat = '0; e_rdat = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    if (busy) begin
      e_cyc  = rq_cyc[m_owner];
      e_stb  = rq_cyc[m_owner] & rq_stb[m_owner];
      e_we   = rq_we[m_owner];
      e_adr  = rq_adr[m_owner*AW +: AW];
      e_wdat = rq_dat[m_owner*DW +: DW];
      e_rdat = s_dat;
    end
    chk("rnd_grant", 128'(grant), 128'(eg));
    chk("rnd_cyc_stb", 128'({wb_cyc, wb_stb}), 128'({e_cyc, e_stb}));
    chk("rnd_adr_we", 128'({wb_adr, wb_we}), 128'({e_adr, e_we}));
    chk("rnd_wdat", wb_dat, e_wdat);
    chk("rnd_rdat", rq_rdat, e_rdat);
    chk("rnd_ack", 128'(rq_ack), (busy && s_ack) ? 128'(eg) : 128'(0));
    chk("rnd_err", 128'(rq_err), ((busy && s_err) || m_abort) ? 128'(eg) : 128'(0));
  endtask

  task automatic model_step();
    if (m_owner < 0) begin
      if (|rq_cyc) begin
        for (int i = NM - 1; i >= 0; i--) begin
          if (rq_cyc[(m_ptr + i) % NM]) m_owner = (m_ptr + i) % NM;
        end
        m_age = 0;
      end
    end else if (m_abort || !rq_cyc[m_owner]) begin
      m_ptr = (m_owner + 1) % NM;
      m_owner = -1;
      m_abort = 1'b0;
      m_age = 0;
    end else if (s_ack || s_err || !rq_stb[m_owner]) begin
      m_age = 0;
    end else begin
      m_age++;
      if (m_age == TO) begin
        m_abort = 1'b1;
        m_age = 0;
      end
    end
  endtask

  typedef struct {
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic        ack;
    logic        e_cyc;
    logic [1:0]  e_grant;
    logic [1:0]  e_ack;
    logic [31:0] e_dat;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int stall;
    logic [31:0] db;
    db = 32'hDEAD_BEEF;

    // Reset state: outputs quiet even with requests and an ack present.
    rst_n = 1'b0;
    clear_inputs();
    rq_cyc = 2'b11; rq_stb = 2'b11; s_ack = 1'b1; s_dat = {96'h0, db};
    #3;
    chk("reset_grant", 128'(grant), 128'(0));
    chk("reset_bus", 128'({wb_cyc, wb_stb}), 128'(0));
    chk("reset_ack_err", 128'({rq_ack, rq_err}), 128'(0));
    chk("reset_rdat", rq_rdat, 128'(0));

    // Single read by master 0, then master 1 burst with master 0 waiting.
    tbl[0]  = '{2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};
    tbl[1]  = '{2'b01, 2'b01, 1'b0, 1'b1, 2'b01, 2'b00, db};
    tbl[2]  = '{2'b01, 2'b01, 1'b0, 1'b1, 2'b01, 2'b00, db};
    tbl[3]  = '{2'b01, 2'b01, 1'b1, 1'b1, 2'b01, 2'b01, db};
    tbl[4]  = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, db};
    tbl[5]  = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};
    tbl[6]  = '{2'b10, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};
    tbl[7]  = '{2'b11, 2'b10, 1'b1, 1'b1, 2'b10, 2'b10, db};
    tbl[8]  = '{2'b11, 2'b10, 1'b1, 1'b1, 2'b10, 2'b10, db};
    tbl[9]  = '{2'b11, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, db};
    tbl[10] = '{2'b11, 2'b10, 1'b1, 1'b1, 2'b10, 2'b10, db};
    tbl[11] = '{2'b11, 2'b10, 1'b1, 1'b1, 2'b10, 2'b10, db};
    tbl[12] = '{2'b01, 2'b01, 1'b0, 1'b0, 2'b10, 2'b00, db};
    tbl[13] = '{2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};
    tbl[14] = '{2'b01, 2'b01, 1'b1, 1'b1, 2'b01, 2'b01, db};
    tbl[15] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, db};
    tbl[16] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};

    do_reset();
    s_dat = {96'h0, db};
    for (int i = 0; i < 17; i++) begin
      rq_cyc = tbl[i].cyc;
      rq_stb = tbl[i].stb;
      s_ack  = tbl[i].ack;
      @(negedge clk);
      chk($sformatf("tbl%0d_cyc", i), 128'(wb_cyc), 128'(tbl[i].e_cyc));
      chk($sformatf("tbl%0d_grant", i), 128'(grant), 128'(tbl[i].e_grant));
      chk($sformatf("tbl%0d_ack", i), 128'(rq_ack), 128'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_dat", i), 128'(rq_rdat[31:0]), 128'(tbl[i].e_dat));
      tick();
    end

    // Both masters always requesting: grants alternate 0,1,0,1.
    do_reset();
    rq_cyc = 2'b11; rq_stb = 2'b11;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_idle_cyc", b), 128'({wb_cyc, grant}), 128'(0));
      tick();
      s_ack = 1'b1;
      @(negedge clk);
      chk($sformatf("rr%0d_grant", b), 128'(grant), 128'(1 << (b % 2)));
      chk($sformatf("rr%0d_ack", b), 128'(rq_ack), 128'(1 << (b % 2)));
      tick();
      s_ack = 1'b0;
      rq_cyc[b % 2] = 1'b0;
      @(negedge clk);
      chk($sformatf("rr%0d_release_cyc", b), 128'(wb_cyc), 128'(0));
      tick();
      rq_cyc = 2'b11;
    end

    // Watchdog abort: slave never responds.
    do_reset();
    rq_cyc = 2'b11; rq_stb = 2'b11;
    tick();
    for (int i = 0; i < int'(TO); i++) begin
      @(negedge clk);
      chk($sformatf("wd_stb%0d", i), 128'({wb_stb, rq_err}), 128'({1'b1, 2'b00}));
      tick();
    end
    @(negedge clk);
    chk("wd_abort_bus", 128'({wb_cyc, wb_stb}), 128'(0));
    chk("wd_abort_err", 128'(rq_err), 128'(2'b01));
    tick();
    @(negedge clk);
    chk("wd_after_err", 128'({rq_err, grant}), 128'(0));
    tick();
    @(negedge clk);
    chk("wd_next_grant", 128'({grant, wb_cyc}), 128'({2'b10, 1'b1}));
    tick();
    rq_cyc = 2'b00; rq_stb = 2'b00;
    tick();
    tick();

    // Ack on the expiry cycle beats the watchdog.
    do_reset();
    rq_cyc = 2'b01; rq_stb = 2'b01;
    tick();
    repeat (TO - 1) tick();
    s_ack = 1'b1;
    @(negedge clk);
    chk("race_ack", 128'({rq_ack, rq_err}), 128'({2'b01, 2'b00}));
    tick();
    s_ack = 1'b0; rq_cyc = 2'b00; rq_stb = 2'b00;
    @(negedge clk);
    chk("race_no_abort", 128'({grant, rq_err}), 128'({2'b01, 2'b00}));
    tick();
    tick();

    // Async reset in the middle of a master 1 burst.
    rq_cyc = 2'b10; rq_stb = 2'b10;
    tick();
    @(negedge clk);
    chk("arst_pre_grant", 128'({grant, wb_cyc}), 128'({2'b10, 1'b1}));
    tick();
    s_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_bus_grant", 128'({wb_cyc, grant}), 128'(0));
    chk("arst_ack_err", 128'({rq_ack, rq_err}), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_ack = 1'b0;
    rq_cyc = 2'b11; rq_stb = 2'b11;
    tick();
    @(negedge clk);
    chk("arst_ptr_zero", 128'(grant), 128'(2'b01));
    tick();
    rq_cyc = 2'b00; rq_stb = 2'b00;
    tick();
    tick();

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    stall = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < int'(NM); k++) begin
        if ($urandom_range(7) == 0) rq_cyc[k] = ~rq_cyc[k];
        rq_stb[k] = rq_cyc[k] & ($urandom_range(3) != 0);
        rq_we[k]  = 1'($urandom_range(1));
        rq_adr[k*AW +: AW] = $urandom;
        rq_sel[k*SW +: SW] = 16'($urandom);
        rq_dat[k*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
      end
      s_dat = {$urandom, $urandom, $urandom, $urandom};
      if (stall > 0) begin
        stall--;
        s_ack = 1'b0;
        s_err = 1'b0;
      end else begin
        if ($urandom_range(15) == 0) stall = 10;
        s_ack = ($urandom_range(3) == 0);
        s_err = !s_ack && ($urandom_range(15) == 0);
      end
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_step();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
